hilo_mac_sequencer: RTL and testbench

Multi-cycle multiply / multiply-accumulate controller that owns the HI/LO register pair for the MiniMIPS datapath. It accepts one HI/LO-class instruction at a time over a valid/ready handshake and runs a radix-2 shift-add multiplier, one bit per cycle. It then writes or accumulates the 64-bit product into {hi, lo}. The single-cycle ALU keeps add/logic/shift/compare work; this block takes the madd, maddu and mul family out of its combinational path.

---
 rtl/hilo_mac_sequencer.sv | 163 ++++++++++++++++
 tb/tb_hilo_mac_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_mac_sequencer.sv
// HI/LO owner for MiniMIPS: radix-2 shift-add mul/multu/madd/maddu plus mthi/mtlo.
// Define HILO_SIGNED_EN to enable signed madd (6) and mul (39); otherwise they raise err.
module hilo_mac_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

    localparam logic [5:0] OpMadd  = 6'd6;
    localparam logic [5:0] OpMaddu = 6'd7;
    localparam logic [5:0] OpMul   = 6'd39;
    localparam logic [5:0] OpMultu = 6'd40;
    localparam logic [5:0] OpMthi  = 6'd41;
    localparam logic [5:0] OpMtlo  = 6'd42;

    typedef enum logic [1:0] {StIdle, StMul, StFix, StWb} state_e;

    state_e              state_q, state_d;
    logic [5:0]          op_q, op_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [XLEN-1:0]     a_mag, b_mag;
    logic                mul_legal;

`ifdef HILO_SIGNED_EN
    logic sign_q, sign_d;
    logic op_signed;

    assign op_signed = (req_op == OpMadd) || (req_op == OpMul);
    // Unsigned XLEN-bit magnitude, so the most negative operand maps to 2^(XLEN-1) exactly.
    assign a_mag = (op_signed && req_a[XLEN-1]) ? (~req_a + XLEN'(1)) : req_a;
    assign b_mag = (op_signed && req_b[XLEN-1]) ? (~req_b + XLEN'(1)) : req_b;
    assign mul_legal = op_signed || (req_op == OpMaddu) || (req_op == OpMultu);
`else
    assign a_mag = req_a;
    assign b_mag = req_b;
    assign mul_legal = (req_op == OpMaddu) || (req_op == OpMultu);
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef HILO_SIGNED_EN
        sign_d   = sign_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_op == OpMthi) begin
                        hi_d   = req_a;
                        done_d = 1'b1;
                    end else if (req_op == OpMtlo) begin
                        lo_d   = req_a;
                        done_d = 1'b1;
                    end else if (mul_legal) begin
                        state_d  = StMul;
                        op_d     = req_op;
                        mcand_d  = {{XLEN{1'b0}}, a_mag};
                        mplier_d = b_mag;
                        acc_d    = '0;
                        cnt_d    = '0;
`ifdef HILO_SIGNED_EN
                        sign_d   = op_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StMul: begin
                // mcand_q is kept pre-shifted by the bit count.
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) state_d = StFix;
            end
            StFix: begin
`ifdef HILO_SIGNED_EN
                if (sign_q) acc_d = ~acc_q + {{(2*XLEN-1){1'b0}}, 1'b1};
`endif
                state_d = StWb;
            end
            StWb: begin
                if ((op_q == OpMadd) || (op_q == OpMaddu)) begin
                    {hi_d, lo_d} = {hi_q, lo_q} + acc_q;
                end else begin
                    {hi_d, lo_d} = acc_q;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef HILO_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef HILO_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_hilo_mac_sequencer.sv
// Directed self-checking bench for hilo_mac_sequencer (XLEN=32).
// Signed-op vectors are exercised only when HILO_SIGNED_EN is defined.
module tb_hilo_mac_sequencer;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    hilo_mac_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request at the negedge; returns just after the next rising edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge: counts edges until done and busy samples before it.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic run_mul(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_hilo);
        int lat;
        int bc;
        issue(op, a, b);
        req_valid = 1'b0;
        wait_done(lat, bc);
        check({tag, " latency"}, 64'(lat), 64'd34);
        check({tag, " hilo"}, {hi, lo}, exp_hilo);
        check({tag, " err"}, {63'd0, err}, 64'd0);
        if (op == 6'd40 && a == 32'hFFFF_FFFF) check({tag, " busy"}, 64'(bc), 64'd34);
    endtask

    task automatic mt(input string tag, input logic [5:0] op, input logic [31:0] a,
                      input logic [63:0] exp_hilo);
        issue(op, a, 32'd0);
        req_valid = 1'b0;
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " ready"}, {63'd0, req_ready}, 64'd1);
        check({tag, " hilo"}, {hi, lo}, exp_hilo);
    endtask

    task automatic bad_op(input logic [5:0] op, input logic [63:0] exp_hilo);
        string tag;
        tag = $sformatf("badop%0d", op);
        issue(op, 32'h1234_5678, 32'h9ABC_DEF0);
        req_valid = 1'b0;
        check({tag, " err"}, {63'd0, err}, 64'd1);
        check({tag, " done"}, {63'd0, done}, 64'd0);
        check({tag, " busy"}, {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, " err pulse"}, {63'd0, err}, 64'd0);
        check({tag, " hilo"}, {hi, lo}, exp_hilo);
    endtask

    initial begin
        int lat;
        int bc;
        bit saw_done;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 6'd0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst hilo", {hi, lo}, 64'd0);
        check("rst ready", {63'd0, req_ready}, 64'd1);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done_err", {62'd0, done, err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_mul("multu ff*ff", 6'd40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_mul("multu 8m*8m", 6'd40, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
`ifdef HILO_SIGNED_EN
        run_mul("mul -3*7", 6'd39, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_mul("mul 8m*8m", 6'd39, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
`endif

        mt("mthi1", 6'd41, 32'h0000_0001, 64'h0000_0001_0000_0000);
        mt("mtlo1", 6'd42, 32'hFFFF_FFFF, 64'h0000_0001_FFFF_FFFF);
        run_mul("maddu carry", 6'd7, 32'd1, 32'd1, 64'h0000_0002_0000_0000);

        mt("mthi2", 6'd41, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
        mt("mtlo2", 6'd42, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef HILO_SIGNED_EN
        run_mul("madd wrap", 6'd6, 32'd2, 32'd1, 64'h0000_0000_0000_0001);
        run_mul("madd -1", 6'd6, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_0000_0000);
        mt("mtlo3", 6'd42, 32'h0000_0001, 64'h0000_0000_0000_0001);
`else
        run_mul("maddu wrap", 6'd7, 32'd2, 32'd1, 64'h0000_0000_0000_0001);
        bad_op(6'd39, 64'h0000_0000_0000_0001);
        bad_op(6'd6, 64'h0000_0000_0000_0001);
`endif
        bad_op(6'd0, 64'h0000_0000_0000_0001);

        // Second request held valid while the first multiply runs.
        issue(6'd40, 32'd3, 32'd5);
        req_a = 32'h0001_0000;
        req_b = 32'h0001_0000;
        wait_done(lat, bc);
        check("b2b first latency", 64'(lat), 64'd34);
        check("b2b first hilo", {hi, lo}, 64'd15);
        check("b2b ready at done", {62'd0, req_ready, busy}, 64'd2);
        @(posedge clk);
        #1;
        check("b2b second accepted", {63'd0, busy}, 64'd1);
        req_valid = 1'b0;
        wait_done(lat, bc);
        check("b2b second latency", 64'(lat), 64'd34);
        check("b2b second hilo", {hi, lo}, 64'h0000_0001_0000_0000);

        // Reset asserted partway through a multiply.
        issue(6'd40, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst hilo", {hi, lo}, 64'd0);
        check("midrst ready", {63'd0, req_ready}, 64'd1);
        check("midrst busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("midrst no done", {63'd0, saw_done}, 64'd0);
        check("midrst hilo after", {hi, lo}, 64'd0);

        run_mul("multu 3*5", 6'd40, 32'd3, 32'd5, 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
